// File: rtl/kan_axis_pkg.sv
// Shared helpers for the KAN AXI-Stream buffering blocks: log2 and sideband width derivation.
package kan_axis_pkg;

  localparam int unsigned USER_WIDTH_ON = 8;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned keep_width(input int unsigned data_width, input bit enable);
    return enable ? (data_width + 7) / 8 : 1;
  endfunction

  function automatic int unsigned user_width(input bit enable);
    return enable ? USER_WIDTH_ON : 1;
  endfunction

endpackage

// File: rtl/axis_multi_fifo_if.sv
// Lane-packed multi-channel AXI-Stream bundle.
interface axis_multi_fifo_if #(
  parameter int unsigned CHANNELS   = 1,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned KEEP_WIDTH = 2,
  parameter int unsigned USER_WIDTH = 1
);
  logic [CHANNELS*DATA_WIDTH-1:0] tdata;
  logic [CHANNELS*KEEP_WIDTH-1:0] tkeep;
  logic [CHANNELS-1:0]            tvalid;
  logic [CHANNELS-1:0]            tready;
  logic [CHANNELS-1:0]            tlast;
  logic [CHANNELS*USER_WIDTH-1:0] tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_chan_fifo.sv
// One FWFT lane: memory, extended pointers, registered ready and fill count.
// Pop is supplied externally so the parent can apply a joint pop across lanes.
module axis_chan_fifo
  import kan_axis_pkg::*;
#(
  parameter int unsigned ENTRY_W = 20,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ENTRY_W-1:0]           in_entry,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         pop,
  output logic [ENTRY_W-1:0]           head_c,
  output logic                         empty_c,
  output logic [clog2(DEPTH+1)-1:0]    fill_count
);

  localparam int unsigned ADDR_W = clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam int unsigned CNT_W  = clog2(DEPTH + 1);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ready_q, ready_d;
  logic               push;

  assign empty_c    = (wr_ptr_q == rd_ptr_q);
  assign head_c     = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign in_ready   = ready_q;
  assign fill_count = count_q;

  // Ready and count are derived from the post-edge pointers so they stay registered.
  always_comb begin
    push     = in_valid & ready_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop & ~empty_c);
    if (push) mem_d[wr_ptr_q[ADDR_W-1:0]] = in_entry;
    ready_d  = !((wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]) &&
                 (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]));
    count_d  = CNT_W'(wr_ptr_d - rd_ptr_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

endmodule

// File: rtl/axis_multi_fifo.sv
// Per-channel AXI-Stream FIFO array with optional lockstep release across lanes
// and a sticky flag for lanes disagreeing on tlast at a joint pop.
module axis_multi_fifo
  import kan_axis_pkg::*;
#(
  parameter int unsigned CHANNELS    = 1,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter bit          KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter bit          LAST_ENABLE = 1'b1,
  parameter bit          USER_ENABLE = 1'b0,
  parameter int unsigned DEPTH       = 4,
  parameter bit          SYNC_MODE   = 1'b0
) (
  input  logic                                clk,
  input  logic                                rst,
  axis_multi_fifo_if.slave                    s_axis,
  axis_multi_fifo_if.master                   m_axis,
  output logic [CHANNELS*clog2(DEPTH+1)-1:0]  fill_count,
  output logic                                last_mismatch
);

  localparam int unsigned KEEP_WIDTH = keep_width(DATA_WIDTH, KEEP_ENABLE);
  localparam int unsigned USER_WIDTH = user_width(USER_ENABLE);
  localparam int unsigned CNT_W      = clog2(DEPTH + 1);
  localparam int unsigned ENTRY_W    = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;

  logic [ENTRY_W-1:0]  entry_c [CHANNELS];
  logic [ENTRY_W-1:0]  head_c  [CHANNELS];
  logic [CHANNELS-1:0] empty_c, valid_c, pop_c, head_last_c, ready_q;
  logic                all_rdy_c;
  logic                last_mismatch_q, last_mismatch_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    axis_chan_fifo #(.ENTRY_W(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .in_entry  (entry_c[i]),
      .in_valid  (s_axis.tvalid[i]),
      .in_ready  (ready_q[i]),
      .pop       (pop_c[i]),
      .head_c    (head_c[i]),
      .empty_c   (empty_c[i]),
      .fill_count(fill_count[i*CNT_W +: CNT_W])
    );
  end

  // Pack inputs into entries and unpack heads, forcing disabled sideband to fixed values.
  always_comb begin
    m_axis.tdata = '0;
    m_axis.tkeep = '0;
    m_axis.tlast = '0;
    m_axis.tuser = '0;
    head_last_c  = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      entry_c[i] = {s_axis.tdata[i*DATA_WIDTH +: DATA_WIDTH],
                    s_axis.tkeep[i*KEEP_WIDTH +: KEEP_WIDTH],
                    s_axis.tlast[i],
                    s_axis.tuser[i*USER_WIDTH +: USER_WIDTH]};
      head_last_c[i] = LAST_ENABLE ? head_c[i][USER_WIDTH] : 1'b0;
      m_axis.tdata[i*DATA_WIDTH +: DATA_WIDTH] = head_c[i][ENTRY_W-1 -: DATA_WIDTH];
      m_axis.tkeep[i*KEEP_WIDTH +: KEEP_WIDTH] =
        KEEP_ENABLE ? head_c[i][USER_WIDTH+1 +: KEEP_WIDTH] : '1;
      m_axis.tlast[i] = head_last_c[i];
      m_axis.tuser[i*USER_WIDTH +: USER_WIDTH] =
        USER_ENABLE ? head_c[i][USER_WIDTH-1:0] : '0;
    end
  end

  // Lockstep mode exposes valid only when every lane has a word and pops all together.
  always_comb begin
    all_rdy_c = &(~empty_c);
    valid_c   = ~empty_c;
    pop_c     = ~empty_c & m_axis.tready;
    if (SYNC_MODE) begin
      valid_c = {CHANNELS{all_rdy_c}};
      pop_c   = {CHANNELS{all_rdy_c & (&m_axis.tready)}};
    end
  end

  always_comb begin
    last_mismatch_d = last_mismatch_q;
    if (SYNC_MODE && (|pop_c) && (|head_last_c) && !(&head_last_c)) last_mismatch_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_mismatch_q <= 1'b0;
    else      last_mismatch_q <= last_mismatch_d;
  end

  assign m_axis.tvalid = valid_c;
  assign s_axis.tready = ready_q;
  assign last_mismatch = last_mismatch_q;

endmodule

// File: tb/tb_axis_multi_fifo.sv
// Bench for axis_multi_fifo: an independent-lane instance and a lockstep instance,
// checked by per-lane reference queues plus a fill/drain vector table.
module tb_axis_multi_fifo;

  logic       clk;
  logic       rst;
  logic [5:0] fc0, fc1;
  logic       lm0, lm1;

  axis_multi_fifo_if #(.CHANNELS(2), .DATA_WIDTH(16), .KEEP_WIDTH(2), .USER_WIDTH(1)) s0 ();
  axis_multi_fifo_if #(.CHANNELS(2), .DATA_WIDTH(16), .KEEP_WIDTH(2), .USER_WIDTH(1)) m0 ();
  axis_multi_fifo_if #(.CHANNELS(2), .DATA_WIDTH(16), .KEEP_WIDTH(1), .USER_WIDTH(8)) s1 ();
  axis_multi_fifo_if #(.CHANNELS(2), .DATA_WIDTH(16), .KEEP_WIDTH(1), .USER_WIDTH(8)) m1 ();

  axis_multi_fifo #(.CHANNELS(2), .DATA_WIDTH(16), .KEEP_ENABLE(1'b1), .LAST_ENABLE(1'b1),
                    .USER_ENABLE(1'b0), .DEPTH(4), .SYNC_MODE(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .s_axis(s0), .m_axis(m0), .fill_count(fc0), .last_mismatch(lm0));

  axis_multi_fifo #(.CHANNELS(2), .DATA_WIDTH(16), .KEEP_ENABLE(1'b0), .LAST_ENABLE(1'b1),
                    .USER_ENABLE(1'b1), .DEPTH(4), .SYNC_MODE(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .s_axis(s1), .m_axis(m1), .fill_count(fc1), .last_mismatch(lm1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  keep;
    logic        last;
    logic [7:0]  user;
  } beat_t;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        r;
    logic        rdy;
    logic [2:0]  cnt;
    logic        vld;
  } vec_t;

  int    n_chk  = 0;
  int    n_fail = 0;
  int    rx_cnt [4];
  beat_t q0[$], q1[$], q2[$], q3[$];
  vec_t  tbl [13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Lanes 0/1 are the independent instance, lanes 2/3 the lockstep instance.
  function automatic logic m_vld(input int l);
    case (l)
      0: return m0.tvalid[0];
      1: return m0.tvalid[1];
      2: return m1.tvalid[0];
      default: return m1.tvalid[1];
    endcase
  endfunction

  function automatic logic m_hs(input int l);
    case (l)
      0: return m0.tvalid[0] & m0.tready[0];
      1: return m0.tvalid[1] & m0.tready[1];
      default: return (&m1.tvalid) & (&m1.tready);
    endcase
  endfunction

  function automatic logic s_hs(input int l);
    case (l)
      0: return s0.tvalid[0] & s0.tready[0];
      1: return s0.tvalid[1] & s0.tready[1];
      2: return s1.tvalid[0] & s1.tready[0];
      default: return s1.tvalid[1] & s1.tready[1];
    endcase
  endfunction

  // Expected output beat for an accepted input: disabled user reads 0, disabled keep reads all-ones.
  function automatic beat_t s_beat(input int l);
    case (l)
      0: return '{data: s0.tdata[15:0],  keep: s0.tkeep[1:0], last: s0.tlast[0], user: 8'h00};
      1: return '{data: s0.tdata[31:16], keep: s0.tkeep[3:2], last: s0.tlast[1], user: 8'h00};
      2: return '{data: s1.tdata[15:0],  keep: 2'b01, last: s1.tlast[0], user: s1.tuser[7:0]};
      default: return '{data: s1.tdata[31:16], keep: 2'b01, last: s1.tlast[1], user: s1.tuser[15:8]};
    endcase
  endfunction

  function automatic beat_t m_beat(input int l);
    case (l)
      0: return '{data: m0.tdata[15:0],  keep: m0.tkeep[1:0], last: m0.tlast[0], user: 8'(m0.tuser[0])};
      1: return '{data: m0.tdata[31:16], keep: m0.tkeep[3:2], last: m0.tlast[1], user: 8'(m0.tuser[1])};
      2: return '{data: m1.tdata[15:0],  keep: 2'(m1.tkeep[0]), last: m1.tlast[0], user: m1.tuser[7:0]};
      default: return '{data: m1.tdata[31:16], keep: 2'(m1.tkeep[1]), last: m1.tlast[1], user: m1.tuser[15:8]};
    endcase
  endfunction

  function automatic int q_size(input int l);
    case (l)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  task automatic q_push(input int l, input beat_t b);
    case (l)
      0: q0.push_back(b);
      1: q1.push_back(b);
      2: q2.push_back(b);
      default: q3.push_back(b);
    endcase
  endtask

  task automatic q_pop_chk(input int l, input beat_t act);
    beat_t e;
    if (q_size(l) == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL lane%0d unexpected beat: got 0x%0h, expected none", l, act);
    end else begin
      case (l)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        2: e = q2.pop_front();
        default: e = q3.pop_front();
      endcase
      rx_cnt[l]++;
      chk($sformatf("lane%0d beat", l), 64'(act), 64'(e));
    end
  endtask

  task automatic q_flush();
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
  endtask

  // One clock: score handshakes seen before the edge, then check stalled heads held steady.
  task automatic tick();
    beat_t hold [4];
    logic  held [4];
    for (int l = 0; l < 4; l++) begin
      held[l] = m_vld(l) && !m_hs(l);
      hold[l] = m_beat(l);
      if (m_hs(l)) q_pop_chk(l, m_beat(l));
      if (s_hs(l)) q_push(l, s_beat(l));
    end
    @(posedge clk);
    #1;
    for (int l = 0; l < 4; l++) begin
      if (held[l]) begin
        chk($sformatf("lane%0d stall valid", l), 64'(m_vld(l)), 64'd1);
        chk($sformatf("lane%0d stall data", l), 64'(m_beat(l)), 64'(hold[l]));
      end
    end
  endtask

  initial begin
    int    sent;
    logic  acc;

    tbl[0]  = '{1'b1, 16'hA000, 1'b0, 1'b1, 3'd1, 1'b1};
    tbl[1]  = '{1'b1, 16'hA003, 1'b0, 1'b1, 3'd2, 1'b1};
    tbl[2]  = '{1'b1, 16'hA005, 1'b0, 1'b1, 3'd3, 1'b1};
    tbl[3]  = '{1'b1, 16'hA006, 1'b0, 1'b0, 3'd4, 1'b1};
    tbl[4]  = '{1'b1, 16'hA007, 1'b0, 1'b0, 3'd4, 1'b1};
    tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 3'd3, 1'b1};
    tbl[6]  = '{1'b1, 16'hA007, 1'b1, 1'b1, 3'd3, 1'b1};
    tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 3'd2, 1'b1};
    tbl[8]  = '{1'b1, 16'hA00A, 1'b1, 1'b1, 3'd2, 1'b1};
    tbl[9]  = '{1'b1, 16'hA00D, 1'b1, 1'b1, 3'd2, 1'b1};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 3'd1, 1'b1};
    tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 3'd0, 1'b0};
    tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 3'd0, 1'b0};

    for (int l = 0; l < 4; l++) rx_cnt[l] = 0;
    rst       = 1'b0;
    s0.tdata  = '0; s0.tkeep = '0; s0.tvalid = '0; s0.tlast = '0; s0.tuser = '1;
    s1.tdata  = '0; s1.tkeep = '0; s1.tvalid = '0; s1.tlast = '0; s1.tuser = '0;
    m0.tready = '0;
    m1.tready = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst tready0", 64'(s0.tready), 64'd0);
    chk("rst tready1", 64'(s1.tready), 64'd0);
    chk("rst tvalid0", 64'(m0.tvalid), 64'd0);
    chk("rst tvalid1", 64'(m1.tvalid), 64'd0);
    chk("rst count0", 64'(fc0), 64'd0);
    chk("rst mismatch1", 64'(lm1), 64'd0);
    rst = 1'b1;
    chk("release tready before edge", 64'(s0.tready), 64'd0);
    tick();
    chk("release tready0", 64'(s0.tready), 64'd3);
    chk("release tready1", 64'(s1.tready), 64'd3);

    // Fill to full, drain, simultaneous push/pop at count 2 (lane 0); lane 1 idle
    m0.tready[1] = 1'b1;
    for (int k = 0; k < 13; k++) begin
      s0.tvalid[0]     = tbl[k].v;
      s0.tdata[15:0]   = tbl[k].d;
      s0.tkeep[1:0]    = tbl[k].d[2:1];
      s0.tlast[0]      = tbl[k].d[0];
      m0.tready[0]     = tbl[k].r;
      tick();
      chk($sformatf("row%0d tready0", k), 64'(s0.tready[0]), 64'(tbl[k].rdy));
      chk($sformatf("row%0d count0", k), 64'(fc0[2:0]), 64'(tbl[k].cnt));
      chk($sformatf("row%0d tvalid0", k), 64'(m0.tvalid[0]), 64'(tbl[k].vld));
      chk($sformatf("row%0d count1", k), 64'(fc0[5:3]), 64'd0);
      chk($sformatf("row%0d tready1", k), 64'(s0.tready[1]), 64'd1);
    end
    chk("table lane0 drained", 64'(q_size(0)), 64'd0);
    chk("table lane0 beats", 64'(rx_cnt[0]), 64'd7);

    // Wrap-around: 20 words through lane 1 with random output ready
    s0.tvalid[0] = 1'b0;
    sent = 0;
    for (int cyc = 0; cyc < 400 && (sent < 20 || q_size(1) != 0); cyc++) begin
      s0.tvalid[1]     = (sent < 20);
      s0.tdata[31:16]  = 16'(sent);
      s0.tkeep[3:2]    = 2'(sent);
      s0.tlast[1]      = (sent == 19);
      m0.tready[1]     = 1'($urandom_range(0, 1));
      acc              = s0.tvalid[1] & s0.tready[1];
      tick();
      if (acc) sent++;
    end
    s0.tvalid[1] = 1'b0;
    chk("wrap words sent", 64'(sent), 64'd20);
    chk("wrap words received", 64'(rx_cnt[1]), 64'd20);
    chk("wrap lane1 drained", 64'(q_size(1)), 64'd0);

    // Reset mid-burst with 3 words stored on lane 0
    m0.tready    = '0;
    s0.tvalid[0] = 1'b1;
    for (int w = 0; w < 3; w++) begin
      s0.tdata[15:0] = 16'hB000 + 16'(w);
      tick();
    end
    chk("burst count0", 64'(fc0[2:0]), 64'd3);
    s0.tdata[15:0] = 16'hB003;
    rst = 1'b0;
    #1;
    chk("async rst tvalid0", 64'(m0.tvalid[0]), 64'd0);
    chk("async rst tready0", 64'(s0.tready), 64'd0);
    q_flush();
    @(posedge clk);
    #1;
    chk("rst next tvalid0", 64'(m0.tvalid), 64'd0);
    chk("rst next count0", 64'(fc0), 64'd0);
    s0.tvalid = '0;
    rst = 1'b1;
    tick();
    chk("rerelease tready0", 64'(s0.tready), 64'd3);
    chk("rerelease tvalid0", 64'(m0.tvalid), 64'd0);

    // Lockstep: lane 0 holds 2 words, lane 1 empty -> no valid
    m1.tready = 2'b11;
    s1.tvalid = 2'b01; s1.tdata[15:0] = 16'h1100; s1.tlast[0] = 1'b0; s1.tuser[7:0] = 8'h11;
    tick();
    s1.tdata[15:0] = 16'h1101; s1.tlast[0] = 1'b1; s1.tuser[7:0] = 8'h12;
    tick();
    chk("sync counts 2/0", 64'(fc1), 64'({3'd0, 3'd2}));
    chk("sync valid one lane empty", 64'(m1.tvalid), 64'd0);
    s1.tvalid = 2'b10; s1.tdata[31:16] = 16'h2200; s1.tlast[1] = 1'b0; s1.tuser[15:8] = 8'h21;
    m1.tready = 2'b01;
    tick();
    chk("sync all valid", 64'(m1.tvalid), 64'd3);
    s1.tvalid = 2'b00;
    tick();
    chk("sync partial ready no pop", 64'(fc1), 64'({3'd1, 3'd2}));
    m1.tready = 2'b11;
    tick();
    chk("sync joint pop counts", 64'(fc1), 64'({3'd0, 3'd1}));
    chk("sync valid after pop", 64'(m1.tvalid), 64'd0);
    chk("sync mismatch clear", 64'(lm1), 64'd0);

    // Heads tlast {1,0} popped jointly -> sticky mismatch
    s1.tvalid = 2'b10; s1.tdata[31:16] = 16'h2201; s1.tlast[1] = 1'b0; s1.tuser[15:8] = 8'h22;
    tick();
    chk("mismatch not yet", 64'(lm1), 64'd0);
    s1.tvalid = 2'b00;
    tick();
    chk("mismatch set", 64'(lm1), 64'd1);
    chk("mismatch counts", 64'(fc1), 64'd0);
    s1.tvalid = 2'b11; s1.tdata = {16'h2202, 16'h1102}; s1.tlast = 2'b11; s1.tuser = 16'h2313;
    tick();
    s1.tvalid = 2'b00;
    tick();
    chk("mismatch sticky", 64'(lm1), 64'd1);
    chk("independent mismatch tied", 64'(lm0), 64'd0);
    chk("sync beats lane0", 64'(rx_cnt[2]), 64'd3);
    chk("sync beats lane1", 64'(rx_cnt[3]), 64'd3);

    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mismatch cleared by reset", 64'(lm1), 64'd0);
    rst = 1'b1;
    tick();
    for (int l = 0; l < 4; l++) chk($sformatf("lane%0d queue empty", l), 64'(q_size(l)), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
